// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the NTT stage sequencer and its helpers.
package ntt_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_BFLY = 3'b011;
  localparam logic [2:0] OP_ROM  = 3'b100;

  localparam int unsigned DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ntt_bfly_addr_gen.sv
// Combinational map from (stage, k) to the butterfly leg addresses and twiddle index
// for an in-place radix-2 Cooley-Tukey walk.
module ntt_bfly_addr_gen #(
  parameter  int unsigned N    = 8,
  localparam int unsigned LOGN = $clog2(N),
  localparam int unsigned SW   = $clog2(LOGN)
) (
  input  logic [SW-1:0]   stage,
  input  logic [LOGN-2:0] k,
  output logic [LOGN-1:0] i0,
  output logic [LOGN-1:0] i1,
  output logic [LOGN-2:0] tw_addr
);

  logic [LOGN-1:0] k_ext;
  logic [LOGN-1:0] m;
  logic [LOGN-1:0] j;
  logic [LOGN-1:0] base;

  always_comb begin
    k_ext   = LOGN'(k);
    m       = LOGN'(1) << stage;
    j       = k_ext & (m - LOGN'(1));
    // Each group of m butterflies spans 2m entries, so the group index is scaled by 2m.
    base    = (k_ext >> stage) << (stage + 1);
    i0      = base + j;
    i1      = i0 + m;
    tw_addr = (LOGN-1)'(j << (LOGN - 1 - stage));
  end

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Drives a registered arithmetic unit through all log2(N) stages of an in-place NTT,
// issuing one butterfly per cycle with a fixed 2-cycle read-to-write pipeline.
module ntt_stage_sequencer #(
  parameter  int unsigned N    = 8,
  localparam int unsigned LOGN = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [63:0]     cfg_q,
  input  logic [63:0]     cfg_mu,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  input  logic [63:0]     rd_data_a,
  input  logic [63:0]     rd_data_b,
  output logic [LOGN-2:0] tw_addr,
  input  logic [63:0]     tw_data,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic [63:0]     wr_data_a,
  output logic [63:0]     wr_data_b,
  output logic [2:0]      au_opcode,
  output logic [63:0]     au_op_a,
  output logic [63:0]     au_op_b,
  output logic [63:0]     au_op_w,
  output logic [63:0]     au_op_q,
  output logic [63:0]     au_op_mu,
  input  logic [63:0]     au_res_1,
  input  logic [63:0]     au_res_2
);
  import ntt_pkg::*;

  localparam int unsigned SW = $clog2(LOGN);
  localparam int unsigned DW = $clog2(DRAIN_CYCLES);

  localparam logic [LOGN-2:0] K_LAST     = '1;
  localparam logic [LOGN-2:0] K_ONE      = (LOGN-1)'(1);
  localparam logic [SW-1:0]   STAGE_LAST = SW'(LOGN - 1);
  localparam logic [SW-1:0]   STAGE_ONE  = SW'(1);
  localparam logic [DW-1:0]   DCNT_LAST  = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]   DCNT_ONE   = DW'(1);

  state_t          state, state_n;
  logic [SW-1:0]   stage, stage_n;
  logic [LOGN-2:0] k, k_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic            issue;
  logic            accept;

  logic [LOGN-1:0] gen_i0;
  logic [LOGN-1:0] gen_i1;
  logic [LOGN-2:0] gen_tw;

  logic            op_valid;
  logic [LOGN-1:0] op_addr_a;
  logic [LOGN-1:0] op_addr_b;

  ntt_bfly_addr_gen #(.N(N)) u_addr_gen (
    .stage   (stage),
    .k       (k),
    .i0      (gen_i0),
    .i1      (gen_i1),
    .tw_addr (gen_tw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      stage <= '0;
      k     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      k     <= k_n;
      dcnt  <= dcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    stage_n = stage;
    k_n     = k;
    dcnt_n  = dcnt;
    issue   = 1'b0;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = ST_RUN;
          stage_n = '0;
          k_n     = '0;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        if (k == K_LAST) begin
          state_n = ST_DRAIN;
          dcnt_n  = '0;
        end else begin
          k_n = k + K_ONE;
        end
      end
      ST_DRAIN: begin
        // The fence lets the stage's last writes retire before the next stage reads them.
        if (dcnt == DCNT_LAST) begin
          if (stage == STAGE_LAST) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_RUN;
            stage_n = stage + STAGE_ONE;
            k_n     = '0;
          end
        end else begin
          dcnt_n = dcnt + DCNT_ONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Read issue (P1), operand stage (P2) and write-back (P3) are all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      op_valid  <= 1'b0;
      op_addr_a <= '0;
      op_addr_b <= '0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      au_op_q   <= '0;
      au_op_mu  <= '0;
    end else begin
      rd_en     <= issue;
      rd_addr_a <= gen_i0;
      rd_addr_b <= gen_i1;
      tw_addr   <= gen_tw;
      op_valid  <= rd_en;
      op_addr_a <= rd_addr_a;
      op_addr_b <= rd_addr_b;
      wr_en     <= op_valid;
      wr_addr_a <= op_addr_a;
      wr_addr_b <= op_addr_b;
      busy      <= (state != ST_IDLE);
      done      <= (state == ST_DONE);
      if (accept) begin
        au_op_q  <= cfg_q;
        au_op_mu <= cfg_mu;
      end
    end
  end

  assign au_opcode = op_valid ? OP_BFLY : OP_ADD;
  assign au_op_a   = rd_data_a;
  assign au_op_b   = rd_data_b;
  assign au_op_w   = tw_data;
  assign wr_data_a = au_res_1;
  assign wr_data_b = au_res_2;

endmodule
